// File: rtl/counter_param_if.sv
// counter_param_if: control, load and status bundle for counter_param
interface counter_param_if #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4
);
  logic                       enb;
  logic [1:0]                 modo;
  logic [WIDTH-1:0]           D;
  logic [WIDTH-1:0]           lim;
  logic                       sat;
  logic [WIDTH-1:0]           Q;
  logic                       rco;
  logic [WIDTH/SEG_WIDTH-1:0] seg_rco;
  modport master (output enb, modo, D, lim, sat, input Q, rco, seg_rco);
  modport slave  (input enb, modo, D, lim, sat, output Q, rco, seg_rco);
endinterface

// File: rtl/counter_param.sv
// counter_param: up/down/load counter with terminal value, saturation and per-segment carries
module counter_param #(
  parameter int WIDTH     = 16,
  parameter int SEG_WIDTH = 4,
  parameter int DOWN_STEP = 3
) (
  input  logic          clk,
  input  logic          reset,
  counter_param_if.slave bus
);
  localparam int NS = WIDTH / SEG_WIDTH;
  localparam logic [WIDTH-1:0] DS = WIDTH'(DOWN_STEP);
  logic [WIDTH-1:0] r_q;
  logic             r_rco;
  logic [NS-1:0]    r_seg;
  logic             w_up_end, w_dn_end, w_ds_end;
  logic [WIDTH-1:0] w_gap, w_wrap3, w_nq;
  logic             w_nrco;
  logic [NS-1:0]    w_all1, w_all0, w_nseg;
  for (genvar g = 0; g < NS; g++) begin : g_seg
    assign w_all1[g] = &r_q[(g+1)*SEG_WIDTH-1:0];
    assign w_all0[g] = ~|r_q[(g+1)*SEG_WIDTH-1:0];
  end
  assign w_up_end = {1'b0, r_q} >= {1'b0, bus.lim};
  assign w_dn_end = r_q == '0;
  assign w_ds_end = {1'b0, r_q} < {1'b0, DS};
  // distance still to borrow past zero; only meaningful when r_q < DS
  assign w_gap    = DS - 1'b1 - r_q;
  assign w_wrap3  = ({1'b0, bus.lim} < {1'b0, w_gap}) ? bus.lim : bus.lim - w_gap;
  always_comb begin
    w_nq   = bus.modo == 2'b11 ? bus.D :
             bus.modo == 2'b00 ? (w_up_end ? (bus.sat ? bus.lim : '0) : r_q + 1'b1) :
             bus.modo == 2'b01 ? (w_dn_end ? (bus.sat ? '0 : bus.lim) : r_q - 1'b1) :
                                 (w_ds_end ? (bus.sat ? '0 : w_wrap3) : r_q - DS);
    w_nrco = bus.modo == 2'b00 ? w_up_end :
             bus.modo == 2'b01 ? w_dn_end :
             bus.modo == 2'b10 ? w_ds_end : 1'b0;
    w_nseg = (bus.modo == 2'b00 && !w_up_end) ? w_all1 :
             (bus.modo == 2'b01 && !w_dn_end) ? w_all0 : '0;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q   <= '0;
      r_rco <= 1'b0;
      r_seg <= '0;
    end else if (!bus.enb) begin
      r_rco <= 1'b0;
      r_seg <= '0;
    end else begin
      r_q   <= w_nq;
      r_rco <= w_nrco;
      r_seg <= w_nseg;
    end
  end
  assign bus.Q       = r_q;
  assign bus.rco     = r_rco;
  assign bus.seg_rco = r_seg;
endmodule

// File: tb/tb_counter_param.sv
// tb_counter_param: scoreboard bench with an arithmetic reference model of the counter
module tb_counter_param;
  localparam int W = 16, SW = 4, DSTEP = 3, NS = W / SW;
  typedef struct {
    logic [W-1:0]  q;
    logic          rco;
    logic [NS-1:0] seg;
  } exp_t;
  logic clk = 0, rst = 1;
  int checks = 0, failures = 0;
  int mq = 0;
  exp_t sb[$];
  counter_param_if #(.WIDTH(W), .SEG_WIDTH(SW)) bus ();
  counter_param #(.WIDTH(W), .SEG_WIDTH(SW), .DOWN_STEP(DSTEP)) dut (
    .clk(clk), .reset(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic step(input logic r, input logic e, input logic [1:0] m,
                      input int d, input int l, input logic s);
    exp_t x;
    int t;
    @(negedge clk);
    rst = r; bus.enb = e; bus.modo = m; bus.D = W'(d); bus.lim = W'(l); bus.sat = s;
    x.rco = 0;
    x.seg = '0;
    if (r) mq = 0;
    else if (e) begin
      if (m == 2'd3) mq = d;
      else if (m == 2'd0) begin
        if (mq >= l) begin mq = s ? l : 0; x.rco = 1; end
        else begin
          for (int i = 0; i < NS; i++) x.seg[i] = (mq % (1 << ((i+1)*SW))) == (1 << ((i+1)*SW)) - 1;
          mq = mq + 1;
        end
      end else if (m == 2'd1) begin
        if (mq == 0) begin mq = s ? 0 : l; x.rco = 1; end
        else begin
          for (int i = 0; i < NS; i++) x.seg[i] = (mq % (1 << ((i+1)*SW))) == 0;
          mq = mq - 1;
        end
      end else begin
        if (mq >= DSTEP) mq = mq - DSTEP;
        else begin
          x.rco = 1;
          t = l - (DSTEP - 1 - mq);
          mq = s ? 0 : (t < 0 ? l : t);
        end
      end
    end
    x.q = W'(mq);
    sb.push_back(x);
  endtask
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        checks++;
        if (bus.Q !== x.q || bus.rco !== x.rco || bus.seg_rco !== x.seg) begin
          failures++;
          $display("FAIL out: got Q=%h rco=%b seg=%b, want Q=%h rco=%b seg=%b",
                   bus.Q, bus.rco, bus.seg_rco, x.q, x.rco, x.seg);
        end
      end
    end
  end
  initial begin
    int l, d;
    bus.enb = 0; bus.modo = 0; bus.D = 0; bus.lim = 0; bus.sat = 0;
    step(1, 1, 3, 'h1234, 'hFFFF, 0);
    step(1, 1, 3, 'h1234, 'hFFFF, 0);
    step(0, 1, 0, 0, 'hFFFF, 0);
    step(0, 1, 3, 'h00FF, 'hFFFF, 0);
    step(0, 1, 0, 0, 'hFFFF, 0);
    step(0, 1, 3, 'h1000, 'hFFFF, 0);
    step(0, 1, 1, 0, 'hFFFF, 0);
    step(0, 1, 3, 'hFFFF, 'hFFFF, 0);
    step(0, 1, 0, 0, 'hFFFF, 0);
    step(0, 1, 1, 0, 'hFFFF, 0);
    step(0, 1, 3, 9, 9, 0);
    step(0, 1, 0, 0, 9, 0);
    step(0, 1, 0, 0, 9, 0);
    step(0, 1, 3, 9, 9, 1);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 9, 1);
    step(0, 1, 3, 1, 9, 0);
    step(0, 1, 2, 0, 9, 0);
    step(0, 1, 2, 0, 9, 0);
    step(0, 1, 3, 1, 9, 1);
    step(0, 1, 2, 0, 9, 1);
    step(0, 1, 2, 0, 9, 1);
    step(0, 1, 3, 0, 0, 0);
    step(0, 1, 2, 0, 0, 0);
    step(0, 1, 3, 'h41, 'hFFFF, 0);
    step(0, 1, 0, 0, 'hFFFF, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 'hFFFF, 0);
    step(1, 1, 0, 0, 'hFFFF, 0);
    step(0, 1, 3, 'h20, 9, 0);
    step(0, 1, 1, 0, 9, 0);
    step(0, 1, 3, 'h20, 9, 0);
    step(0, 1, 0, 0, 9, 0);
    for (int i = 0; i < 3000; i++) begin
      case ($urandom_range(0, 3))
        0: l = $urandom_range(0, 15);
        1: l = 'hFFFF;
        2: l = $urandom_range(0, 300);
        default: l = $urandom_range(0, 'hFFFF);
      endcase
      d = $urandom_range(0, 1) ? $urandom_range(0, 'hFFFF) : $urandom_range(0, 20);
      step($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0,
           2'($urandom_range(0, 3) == 3 && $urandom_range(0, 3) != 0 ? $urandom_range(0, 2) : $urandom_range(0, 3)),
           d, l, 1'($urandom_range(0, 1)));
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d pending, want 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/counter_param.md
Name: counter_param

Overview:
- Parametrised synchronous up/down/load counter. Next generation of the team's 4-bit/16-bit `modo`-controlled counters.
- Adds:
  - a programmable terminal value (`lim`) for modulo counting;
  - a saturation option;
  - a configurable down-step;
  - a per-segment carry vector that replaces hand-wired `rco1..rco4` cascades.
- Sits wherever the design needs an event or timebase counter; the per-segment carries feed downstream nibble-oriented logic.

Parameters:
- WIDTH, 16, counter width in bits. Must be a multiple of SEG_WIDTH.
- SEG_WIDTH, 4, segment width for seg_rco reporting.
- DOWN_STEP, 3, decrement used in modo=10. Range 1..2**WIDTH-1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- enb  in  1  count enable
- modo  in  2  00 up by 1, 01 down by 1, 10 down by DOWN_STEP, 11 load D
- D  in  WIDTH  load value
- lim  in  WIDTH  terminal value; counting range is 0..lim
- sat  in  1  1 = saturate at the bounds instead of wrapping
- Q  out  WIDTH  registered count
- rco  out  1  registered wrap/bound event flag
- seg_rco  out  WIDTH/SEG_WIDTH  registered per-segment carry/borrow flags

Behaviour:
- **Clock, reset and priority**
  - All outputs are registered and update only on the rising edge of clk.
  - Priority: reset > enb=0 > modo.
- **Reset:** reset=1 at an edge gives Q=0, rco=0, seg_rco=0, regardless of enb, modo or a load in progress.
- **Hold:** enb=0 holds Q; rco=0 and seg_rco=0 that cycle.
- **Latency:** one cycle. The Q value and flags resulting from the inputs sampled at edge N are visible after edge N.
- **modo=11 (load):** Q<=D, even if D>lim. rco=0, seg_rco=0.
- **modo=00 (up):**
  - Q<lim: Q<=Q+1, rco=0.
  - Q>=lim, sat=0: Q<=0, rco=1.
  - Q>=lim, sat=1: Q<=lim, rco=1.
- **modo=01 (down by 1):**
  - Q>0: Q<=Q-1, rco=0. If Q>lim (after a load), count down normally until reaching the 0..lim range.
  - Q=0, sat=0: Q<=lim, rco=1.
  - Q=0, sat=1: Q holds 0, rco=1.
- **modo=10 (down by DOWN_STEP):**
  - Q>=DOWN_STEP: Q<=Q-DOWN_STEP, rco=0.
  - Q<DOWN_STEP, sat=0: Q<=lim-(DOWN_STEP-1-Q), i.e. modulo lim+1. If that subtraction would underflow, Q<=lim. rco=1.
  - Q<DOWN_STEP, sat=1: Q<=0, rco=1.
- **rco while saturated:** asserts every enabled cycle that the counter is pinned at a bound.
- **seg_rco[i]** (segment i = Q bits i*SEG_WIDTH .. (i+1)*SEG_WIDTH-1):
  - modo=00: 1 when the update is a plain +1 (no lim wrap or saturation) and old Q segments 0..i are all ones.
  - modo=01: 1 when the update is a plain -1 and old Q segments 0..i are all zeros.
  - modo=10, modo=11, lim wrap, saturation: seg_rco=0.
- **Width rules:**
  - Internal compare and subtract use WIDTH+1 bits; no truncation before the compare.
  - lim=all-ones reproduces plain binary wrap.
- **Input changes:** lim and sat changes take effect at the next edge. There is no internal copy of lim.

Test Plan (WIDTH=16, SEG_WIDTH=4, DOWN_STEP=3):
1. **Reset priority:** reset=1 for 2 cycles with enb=1, modo=11, D=0x1234 -> Q=0x0000, rco=0, seg_rco=0000. Release with modo=00, lim=0xFFFF -> Q=0x0001 next cycle.
2. **Segment carries:** load D=0x00FF, then modo=00, lim=0xFFFF -> Q=0x0100, seg_rco=0011, rco=0. Then load 0x1000, modo=01 -> Q=0x0FFF, seg_rco=0111.
3. **Modulo-10 up:** lim=0x0009, load 0x0009, modo=00, sat=0 -> Q=0x0000, rco=1 for one cycle, then Q=1, rco=0. Repeat with sat=1 -> Q stays 0x0009, rco=1 every cycle.
4. **Down-by-3 wrap:** lim=0x0009, load 0x0001, modo=10 -> Q=0x0008, rco=1. Next edge -> Q=0x0005, rco=0. Same start with sat=1 -> Q=0x0000, rco=1.
5. **Hold and mid-count reset:** counting up at Q=0x0042, enb=0 for 3 cycles -> Q stays 0x0042, rco=0, seg_rco=0. Then enb=1 with reset=1 at the same edge -> Q=0x0000.
6. **Load above lim:** lim=0x0009, load 0x0020, modo=01 -> Q=0x001F, rco=0. Same load with modo=00 -> Q=0x0000, rco=1.
